perm_engine: RTL and testbench

- Parametrised, runtime-programmable bit-permutation engine; successor to the fixed 64-bit inverse permutation block.
- Holds a forward map loaded over a write port and builds its inverse internally, so one instance serves both directions.
- Selects forward or inverse per word and streams words through valid/ready handshakes.
- Sits between cipher round logic and the data bus wherever an initial or final permutation is needed.

---
 rtl/perm_pkg.sv | 35 +++
 rtl/perm_engine_if.sv | 43 ++++
 rtl/perm_engine_xbar.sv | 22 ++
 rtl/perm_engine.sv | 191 +++++++++++++++++++
 tb/tb_perm_engine.sv | 279 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/perm_pkg.sv
// Shared types and helpers for the runtime-programmable bit-permutation engine.
// Holds the map-builder state encoding, the data-path mode constants and the
// identity-map generator used to load both maps at reset.
package perm_pkg;

  typedef enum logic [1:0] {
    READY = 2'd0,
    DIRTY = 2'd1,
    BUILD = 2'd2,
    ERROR = 2'd3
  } perm_state_t;

  localparam logic PERM_FWD = 1'b0;
  localparam logic PERM_INV = 1'b1;

  // identity_map() returns a map sized for the largest supported instance.
  // Entries at or above the requested width are zero. Instances may use up to
  // PERM_MAX_WIDTH bits, so their index width never exceeds PERM_MAX_IDX_W.
  localparam int PERM_MAX_WIDTH = 256;
  localparam int PERM_MAX_IDX_W = 8;

  typedef logic [PERM_MAX_WIDTH-1:0][PERM_MAX_IDX_W-1:0] perm_map_t;

  function automatic perm_map_t identity_map(input int width);
    perm_map_t m;
    m = '0;
    for (int i = 0; i < PERM_MAX_WIDTH; i++) begin
      if (i < width) begin
        m[i] = PERM_MAX_IDX_W'(i);
      end
    end
    return m;
  endfunction

endpackage

// File: rtl/perm_engine_if.sv
// Bus bundle for perm_engine: map programming port, input stream and output
// stream. The master modport is the side that drives words and map entries;
// the engine itself sits on the slave modport. Data words use [0:WIDTH-1]
// ordering, so bit 0 is the MSB.
interface perm_engine_if #(
  parameter int WIDTH = 64,
  parameter int IDX_W = $clog2(WIDTH)
);

  logic             map_we;
  logic [IDX_W-1:0] map_addr;
  logic [IDX_W-1:0] map_data;
  logic             map_commit;
  logic             map_busy;
  logic             map_ok;
  logic             map_err;

  logic             in_valid;
  logic             in_ready;
  logic [0:WIDTH-1] in_data;
  logic             in_mode;

  logic             out_valid;
  logic             out_ready;
  logic [0:WIDTH-1] out_data;

  logic             status;

  modport master (
    output map_we, map_addr, map_data, map_commit,
    output in_valid, in_data, in_mode, out_ready,
    input  map_busy, map_ok, map_err,
    input  in_ready, out_valid, out_data, status
  );

  modport slave (
    input  map_we, map_addr, map_data, map_commit,
    input  in_valid, in_data, in_mode, out_ready,
    output map_busy, map_ok, map_err,
    output in_ready, out_valid, out_data, status
  );

endinterface

// File: rtl/perm_engine_xbar.sv
// perm_xbar: purely combinational WIDTH-way bit selector. Output bit i takes
// the input bit named by map entry i (flattened, entry i at bits
// [i*IDX_W +: IDX_W]). Entries that point past the word select a zero so a
// bad map on a non-power-of-two width never indexes outside the word.
module perm_xbar
  import perm_pkg::*;
#(
  parameter int WIDTH = 64,
  parameter int IDX_W = $clog2(WIDTH)
) (
  input  logic [WIDTH*IDX_W-1:0] map_i,
  input  logic [0:WIDTH-1]       data_i,
  output logic [0:WIDTH-1]       data_o
);

  for (genvar i = 0; i < WIDTH; i++) begin : g_bit
    logic [IDX_W-1:0] src;
    assign src       = map_i[i*IDX_W +: IDX_W];
    assign data_o[i] = (32'(src) < WIDTH) ? data_i[src] : 1'b0;
  end

endmodule

// File: rtl/perm_engine.sv
// perm_engine: runtime-programmable bit-permutation engine.
// A forward map is written entry by entry; a commit walks the map once per
// cycle to build the inverse, so each word can be permuted either way through
// one shared crossbar. Words stream through a one-deep registered output stage
// with valid/ready handshakes on both sides.
// Optional feature macro: PERM_DUP_CHECK_EN enables duplicate/range checking
// of the forward map during the build (ERROR state reachable, map_err live).
// Without it the build always ends in READY and map_err is tied low.
// WIDTH is limited to perm_pkg::PERM_MAX_WIDTH.
module perm_engine
  import perm_pkg::*;
#(
  parameter int WIDTH = 64
) (
  input logic          clk,
  input logic          set,
  perm_engine_if.slave bus
);

  localparam int               IDX_W  = $clog2(WIDTH);
  localparam perm_map_t        ID_MAP = identity_map(WIDTH);
  localparam logic [IDX_W-1:0] LAST_K = IDX_W'(WIDTH - 1);

  perm_state_t                  state_q;
  logic [WIDTH-1:0][IDX_W-1:0]  fmap_q;
  logic [WIDTH-1:0][IDX_W-1:0]  imap_q;
  logic [IDX_W-1:0]             k_q;
  logic                         map_busy_q;
  logic                         map_ok_q;

  logic [IDX_W-1:0]             build_src;
  logic                         build_in_range;
  logic                         map_write;

`ifdef PERM_DUP_CHECK_EN
  logic [WIDTH-1:0]             seen_q;
  logic                         dup_q;
  logic                         map_err_q;
  logic                         build_bad;
`endif

  logic                         in_ready;
  logic                         accept;
  logic                         out_valid_q, out_valid_d;
  logic                         status_q, status_d;
  logic [0:WIDTH-1]             out_data_q, out_data_d;
  logic [0:WIDTH-1]             xbar_out;
  logic [WIDTH*IDX_W-1:0]       sel_map;

  assign build_src      = fmap_q[k_q];
  assign build_in_range = (32'(build_src) < WIDTH);
  assign map_write      = bus.map_we && (state_q != BUILD) &&
                          (32'(bus.map_addr) < WIDTH);

`ifdef PERM_DUP_CHECK_EN
  assign build_bad = ~build_in_range | seen_q[build_src];
`endif

  // Map-builder FSM: stores forward-map writes, walks the map on commit to
  // build the inverse, and drives the registered busy/ok/err flags.
  always_ff @(posedge clk) begin
    if (set) begin
      state_q    <= READY;
      map_busy_q <= 1'b0;
      map_ok_q   <= 1'b1;
      k_q        <= '0;
      for (int i = 0; i < WIDTH; i++) begin
        fmap_q[i] <= IDX_W'(ID_MAP[i]);
        imap_q[i] <= IDX_W'(ID_MAP[i]);
      end
`ifdef PERM_DUP_CHECK_EN
      seen_q    <= '0;
      dup_q     <= 1'b0;
      map_err_q <= 1'b0;
`endif
    end else begin
      if (map_write) begin
        fmap_q[bus.map_addr] <= bus.map_data;
      end
      case (state_q)
        READY, DIRTY, ERROR: begin
          if (bus.map_commit) begin
            state_q    <= BUILD;
            map_busy_q <= 1'b1;
            map_ok_q   <= 1'b0;
            k_q        <= '0;
`ifdef PERM_DUP_CHECK_EN
            seen_q     <= '0;
            dup_q      <= 1'b0;
            map_err_q  <= 1'b0;
`endif
          end else if (bus.map_we) begin
            state_q  <= DIRTY;
            map_ok_q <= 1'b0;
`ifdef PERM_DUP_CHECK_EN
            map_err_q <= 1'b0;
`endif
          end
        end
        BUILD: begin
          if (build_in_range) begin
            imap_q[build_src] <= k_q;
          end
`ifdef PERM_DUP_CHECK_EN
          if (build_in_range) begin
            seen_q[build_src] <= 1'b1;
          end
          if (build_bad) begin
            dup_q <= 1'b1;
          end
`endif
          if (k_q == LAST_K) begin
            map_busy_q <= 1'b0;
            k_q        <= '0;
`ifdef PERM_DUP_CHECK_EN
            if (dup_q || build_bad) begin
              state_q   <= ERROR;
              map_err_q <= 1'b1;
              map_ok_q  <= 1'b0;
            end else begin
              state_q  <= READY;
              map_ok_q <= 1'b1;
            end
`else
            state_q  <= READY;
            map_ok_q <= 1'b1;
`endif
          end else begin
            k_q <= k_q + 1'b1;
          end
        end
        default: begin
          state_q <= READY;
        end
      endcase
    end
  end

  assign sel_map = (bus.in_mode == PERM_INV) ? imap_q : fmap_q;

  perm_xbar #(
    .WIDTH (WIDTH),
    .IDX_W (IDX_W)
  ) u_xbar (
    .map_i  (sel_map),
    .data_i (bus.in_data),
    .data_o (xbar_out)
  );

  assign in_ready = map_ok_q & (~out_valid_q | bus.out_ready);
  assign accept   = bus.in_valid & in_ready;

  // Output stage next state: load on accept, drain on handshake, otherwise hold.
  always_comb begin
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    status_d    = status_q | (out_valid_q & bus.out_ready);
    if (accept) begin
      out_valid_d = 1'b1;
      out_data_d  = xbar_out;
    end else if (bus.out_ready) begin
      out_valid_d = 1'b0;
    end
  end

  // Output stage registers; reset drops any held word and clears status.
  always_ff @(posedge clk) begin
    if (set) begin
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      status_q    <= 1'b0;
    end else begin
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      status_q    <= status_d;
    end
  end

  assign bus.map_busy  = map_busy_q;
  assign bus.map_ok    = map_ok_q;
`ifdef PERM_DUP_CHECK_EN
  assign bus.map_err   = map_err_q;
`else
  assign bus.map_err   = 1'b0;
`endif
  assign bus.in_ready  = in_ready;
  assign bus.out_valid = out_valid_q;
  assign bus.out_data  = out_data_q;
  assign bus.status    = status_q;

endmodule

// File: tb/tb_perm_engine.sv
// Testbench for perm_engine at WIDTH=8. Directed steps cover reset, reverse and
// rotate maps, backpressure, invalid maps and reset during a build; random maps
// and words are then checked against a map-array reference model.
module tb_perm_engine;
  import perm_pkg::*;

  localparam int W = 8;

  logic clk = 1'b0;
  logic set;

  perm_engine_if #(.WIDTH(W)) bus ();

  perm_engine #(.WIDTH(W)) dut (
    .clk (clk),
    .set (set),
    .bus (bus.slave)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  int   fm [W];
  logic modelOk;

  int revMap [W] = '{7, 6, 5, 4, 3, 2, 1, 0};
  int rotMap [W] = '{1, 2, 3, 4, 5, 6, 7, 0};
  int dupMap [W] = '{0, 0, 2, 3, 4, 5, 6, 7};
  int rndMap [W];

  logic [0:W-1] qW[$];
  logic         qM[$];
  logic         qR[$];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference: out[i] = in[map[i]], inverse map built from imap[fm[k]] = k.
  function automatic logic [0:W-1] modelPermute(input logic [0:W-1] word, input logic mode);
    int           imap [W];
    logic [0:W-1] r;
    for (int k = 0; k < W; k++) imap[fm[k]] = k;
    for (int i = 0; i < W; i++) r[i] = (mode == PERM_INV) ? word[imap[i]] : word[fm[i]];
    return r;
  endfunction

  task automatic setModelIdentity();
    for (int i = 0; i < W; i++) fm[i] = i;
  endtask

  // Writes all entries; the last one goes in the same cycle as the commit.
  task automatic loadMap(input int m [W], input string tag);
    int n;
    for (int i = 0; i < W; i++) begin
      bus.map_we     = 1'b1;
      bus.map_addr   = 3'(m[i] == m[i] ? i : 0);
      bus.map_data   = 3'(m[i]);
      bus.map_commit = (i == W - 1);
      tick();
      if (i == 0) checkOutput({tag, "_dirty_ok"}, bus.map_ok, 1'b0);
    end
    bus.map_we     = 1'b0;
    bus.map_commit = 1'b0;
    n = 0;
    while (bus.map_busy === 1'b1 && n < 100) begin
      n++;
      tick();
    end
    checkOutput({tag, "_busy_cycles"}, n, W);
  endtask

  task automatic applyStimulus(input logic [0:W-1] word, input logic mode, input logic [0:W-1] exp,
                               input string tag);
    bus.in_valid  = 1'b1;
    bus.in_data   = word;
    bus.in_mode   = mode;
    bus.out_ready = 1'b1;
    #1;
    checkOutput({tag, "_in_ready"}, bus.in_ready, 1'b1);
    tick();
    bus.in_valid = 1'b0;
    checkOutput({tag, "_out_valid"}, bus.out_valid, 1'b1);
    checkOutput({tag, "_out_data"}, bus.out_data, exp);
    tick();
    checkOutput({tag, "_drained"}, bus.out_valid, 1'b0);
  endtask

  // Streams qW/qM with per-cycle out_ready from qR; a queue scoreboard of
  // model results holds the word expected in the output register.
  task automatic runStream(input bit gaps, input string tag);
    logic [0:W-1] sb[$];
    int           idx;
    int           cyc;
    int           delivered;
    logic         iv;
    logic         ordy;
    logic         expReady;
    idx = 0;
    cyc = 0;
    delivered = 0;
    while ((idx < qW.size() || sb.size() > 0) && cyc < 500) begin
      iv = (idx < qW.size()) && (!gaps || $urandom_range(0, 3) != 0);
      ordy = 1'b1;
      if (cyc < qR.size()) ordy = qR[cyc];
      bus.in_valid  = iv;
      bus.in_data   = '0;
      bus.in_mode   = 1'b0;
      if (iv) begin
        bus.in_data = qW[idx];
        bus.in_mode = qM[idx];
      end
      bus.out_ready = ordy;
      #1;
      expReady = modelOk && (sb.size() == 0 || ordy);
      checkOutput({tag, "_in_ready"}, bus.in_ready, expReady);
      checkOutput({tag, "_out_valid"}, bus.out_valid, sb.size() != 0);
      if (sb.size() != 0) checkOutput({tag, "_out_data"}, bus.out_data, sb[0]);
      if (sb.size() != 0 && ordy) begin
        void'(sb.pop_front());
        delivered++;
      end
      if (iv && expReady) begin
        sb.push_back(modelPermute(qW[idx], qM[idx]));
        idx++;
      end
      cyc++;
      tick();
    end
    bus.in_valid = 1'b0;
    checkOutput({tag, "_delivered"}, delivered, qW.size());
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog expired total=%0d bad=%0d", total, bad);
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    set            = 1'b1;
    bus.map_we     = 1'b0;
    bus.map_addr   = '0;
    bus.map_data   = '0;
    bus.map_commit = 1'b0;
    bus.in_valid   = 1'b0;
    bus.in_data    = '0;
    bus.in_mode    = 1'b0;
    bus.out_ready  = 1'b0;
    tick();
    tick();
    set = 1'b0;
    setModelIdentity();
    modelOk = 1'b1;

    $display("[TB] reset state");
    checkOutput("rst_map_ok", bus.map_ok, 1'b1);
    checkOutput("rst_map_err", bus.map_err, 1'b0);
    checkOutput("rst_map_busy", bus.map_busy, 1'b0);
    checkOutput("rst_out_valid", bus.out_valid, 1'b0);
    checkOutput("rst_out_data", bus.out_data, 8'h00);
    checkOutput("rst_status", bus.status, 1'b0);

    $display("[TB] identity maps");
    applyStimulus(8'hB4, PERM_FWD, 8'hB4, "id_fwd");
    checkOutput("id_status", bus.status, 1'b1);
    applyStimulus(8'hB4, PERM_INV, 8'hB4, "id_inv");

    $display("[TB] held word survives map load, reverse map");
    bus.in_valid  = 1'b1;
    bus.in_data   = 8'hB4;
    bus.in_mode   = PERM_FWD;
    bus.out_ready = 1'b0;
    tick();
    bus.in_valid = 1'b0;
    loadMap(revMap, "rev");
    checkOutput("rev_ok", bus.map_ok, 1'b1);
    checkOutput("rev_err", bus.map_err, 1'b0);
    checkOutput("held_valid", bus.out_valid, 1'b1);
    checkOutput("held_data", bus.out_data, 8'hB4);
    bus.out_ready = 1'b1;
    tick();
    checkOutput("held_drained", bus.out_valid, 1'b0);
    fm = revMap;
    applyStimulus(8'hB4, PERM_FWD, 8'h2D, "rev_fwd");
    applyStimulus(8'hB4, PERM_INV, 8'h2D, "rev_inv");

    $display("[TB] rotate map");
    loadMap(rotMap, "rot");
    fm = rotMap;
    applyStimulus(8'hB4, PERM_FWD, 8'h69, "rot_fwd");
    applyStimulus(8'hB4, PERM_INV, 8'h5A, "rot_inv");
    applyStimulus(8'h69, PERM_INV, 8'hB4, "rot_trip");

    $display("[TB] backpressure");
    qW = '{8'hB4, 8'h69, 8'h3C, 8'hE1};
    qM = '{1'b0, 1'b1, 1'b0, 1'b1};
    qR = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b1};
    runStream(1'b0, "bp");

    $display("[TB] invalid map");
    loadMap(dupMap, "dup");
`ifdef PERM_DUP_CHECK_EN
    checkOutput("dup_err", bus.map_err, 1'b1);
    checkOutput("dup_ok", bus.map_ok, 1'b0);
    bus.in_valid = 1'b1;
    bus.in_data  = 8'hB4;
    #1;
    checkOutput("dup_in_ready", bus.in_ready, 1'b0);
    bus.in_valid = 1'b0;
`else
    checkOutput("dup_err", bus.map_err, 1'b0);
    checkOutput("dup_ok", bus.map_ok, 1'b1);
`endif
    loadMap(revMap, "fix");
    fm = revMap;
    checkOutput("fix_err", bus.map_err, 1'b0);
    checkOutput("fix_ok", bus.map_ok, 1'b1);
    applyStimulus(8'hB4, PERM_FWD, 8'h2D, "fix_fwd");

    $display("[TB] random maps and traffic");
    for (int r = 0; r < 3; r++) begin
      for (int i = 0; i < W; i++) rndMap[i] = i;
      for (int i = W - 1; i > 0; i--) begin
        int j;
        int t;
        j = $urandom_range(0, i);
        t = rndMap[i];
        rndMap[i] = rndMap[j];
        rndMap[j] = t;
      end
      loadMap(rndMap, "rnd");
      fm = rndMap;
      qW.delete();
      qM.delete();
      qR.delete();
      for (int i = 0; i < 16; i++) begin
        qW.push_back(8'($urandom));
        qM.push_back(1'($urandom));
      end
      for (int i = 0; i < 40; i++) qR.push_back($urandom_range(0, 2) != 0);
      runStream(1'b1, "rnd");
    end

    $display("[TB] reset during build");
    loadMap(rotMap, "pre");
    bus.map_commit = 1'b1;
    tick();
    bus.map_commit = 1'b0;
    checkOutput("abort_busy_before", bus.map_busy, 1'b1);
    tick();
    tick();
    set = 1'b1;
    tick();
    set = 1'b0;
    setModelIdentity();
    checkOutput("abort_busy", bus.map_busy, 1'b0);
    checkOutput("abort_ok", bus.map_ok, 1'b1);
    checkOutput("abort_err", bus.map_err, 1'b0);
    checkOutput("abort_status", bus.status, 1'b0);
    applyStimulus(8'hB4, PERM_FWD, 8'hB4, "abort_fwd");
    applyStimulus(8'hB4, PERM_INV, 8'hB4, "abort_inv");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
